hazard_scoreboard_unit: RTL and testbench

- Parametrised successor hazard unit for the in-order pipeline.
- Adds a per-register scoreboard of outstanding long-latency writes (variable-latency loads, mul/div) on top of the EX load-use interlock.
- Adds a multi-cycle flush window sized to the number of younger stages killed on a redirect.
- Sits beside the ID stage and drives the IF/ID stall and flush controls.

---
 rtl/hazard_pkg.sv | 14 +
 rtl/hazard_scoreboard_unit_if.sv | 45 ++++
 rtl/hazard_scoreboard.sv | 61 ++++++
 rtl/hazard_scoreboard_unit.sv | 88 ++++++++
 tb/tb_hazard_scoreboard_unit.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared types and defaults for the ID-stage hazard unit and its scoreboard.
package hazard_pkg;

  localparam int unsigned NUM_REGS_DEF    = 32;
  localparam int unsigned CNT_W_DEF       = 2;
  localparam int unsigned FLUSH_DEPTH_DEF = 2;
  localparam int unsigned REG_AW          = $clog2(NUM_REGS_DEF);

  typedef logic [REG_AW-1:0]    reg_addr_t;
  typedef logic [CNT_W_DEF-1:0] sb_cnt_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/hazard_scoreboard_unit_if.sv
// ID/EX/WB hazard inputs and IF/ID control outputs of the hazard unit.
interface hazard_scoreboard_unit_if #(
  parameter int unsigned NUM_REGS = 32
);
  localparam int unsigned AW = $clog2(NUM_REGS);

  logic          i_id_valid;
  logic [AW-1:0] i_id_rs1;
  logic [AW-1:0] i_id_rs2;
  logic          i_id_uses_rs1;
  logic          i_id_uses_rs2;
  logic [AW-1:0] i_id_rd;
  logic          i_id_writes_rd;
  logic          i_id_long_lat;
  logic          i_ex_valid;
  logic [AW-1:0] i_ex_rd;
  logic          i_ex_is_load;
  logic          i_wb_valid;
  logic [AW-1:0] i_wb_rd;
  logic          i_wb_long_lat;
  logic          i_branch_taken;
  logic          i_jump_taken;
  logic          o_stall;
  logic          o_flush;
  logic [NUM_REGS-1:0] o_pending;
  logic          o_busy;
  logic          o_sb_err;

  modport master (
    output i_id_valid, i_id_rs1, i_id_rs2, i_id_uses_rs1, i_id_uses_rs2,
           i_id_rd, i_id_writes_rd, i_id_long_lat, i_ex_valid, i_ex_rd,
           i_ex_is_load, i_wb_valid, i_wb_rd, i_wb_long_lat,
           i_branch_taken, i_jump_taken,
    input  o_stall, o_flush, o_pending, o_busy, o_sb_err
  );

  modport slave (
    input  i_id_valid, i_id_rs1, i_id_rs2, i_id_uses_rs1, i_id_uses_rs2,
           i_id_rd, i_id_writes_rd, i_id_long_lat, i_ex_valid, i_ex_rd,
           i_ex_is_load, i_wb_valid, i_wb_rd, i_wb_long_lat,
           i_branch_taken, i_jump_taken,
    output o_stall, o_flush, o_pending, o_busy, o_sb_err
  );

endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register outstanding long-latency write counters with zero/one/max queries.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [NUM_REGS-1:0] i_inc,
  input  logic [NUM_REGS-1:0] i_dec,
  output logic [NUM_REGS-1:0] o_is_zero,
  output logic [NUM_REGS-1:0] o_is_one,
  output logic [NUM_REGS-1:0] o_is_max,
  output logic                o_sb_err
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q [NUM_REGS];
  logic [CNT_W-1:0] cnt_d [NUM_REGS];
  logic             sb_err_q, sb_err_d;

  always_comb begin
    sb_err_d = sb_err_q;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if (r == 0) begin
        cnt_d[r] = '0;
      end else if (i_inc[r] && !i_dec[r]) begin
        if (cnt_q[r] != CNT_MAX) cnt_d[r] = cnt_q[r] + CNT_ONE;
      end else if (!i_inc[r] && i_dec[r]) begin
        // Retiring something never issued: hold at zero and latch the error.
        if (cnt_q[r] == '0) sb_err_d = 1'b1;
        else                cnt_d[r] = cnt_q[r] - CNT_ONE;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
      sb_err_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      sb_err_q <= sb_err_d;
    end
  end

  always_comb begin
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      o_is_zero[r] = (cnt_q[r] == '0);
      o_is_one[r]  = (cnt_q[r] == CNT_ONE);
      o_is_max[r]  = (cnt_q[r] == CNT_MAX);
    end
  end

  assign o_sb_err = sb_err_q;

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// ID-stage hazard unit: load-use interlock, long-latency scoreboard and multi-cycle redirect flush.
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_REGS    = NUM_REGS_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned FLUSH_DEPTH = FLUSH_DEPTH_DEF
) (
  input logic                     i_clk,
  input logic                     i_rst_n,
  hazard_scoreboard_unit_if.slave bus
);

  localparam int unsigned AW   = $clog2(NUM_REGS);
  localparam int unsigned FC_W = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;
  localparam logic [AW-1:0] RZ = AW'(REG_ZERO);

  logic                active_q, active_d;
  logic [FC_W-1:0]     flush_cnt_q, flush_cnt_d;
  logic [NUM_REGS-1:0] inc, dec, is_zero, is_one, is_max;
  logic                sb_err;
  logic                redirect, flush, stall, issue;
  logic                load_use, raw1, raw2, waw, ovf;

  always_comb begin
    // active_q masks every control for the first cycle after reset release.
    active_d = 1'b1;
    redirect = active_q & (bus.i_branch_taken | bus.i_jump_taken);
    flush    = active_q & (redirect | (flush_cnt_q != '0));

    flush_cnt_d = flush_cnt_q;
    if (redirect)                flush_cnt_d = FC_W'(FLUSH_DEPTH - 1);
    else if (flush_cnt_q != '0)  flush_cnt_d = flush_cnt_q - FC_W'(1);

    for (int unsigned r = 0; r < NUM_REGS; r++)
      dec[r] = bus.i_wb_valid & bus.i_wb_long_lat & (bus.i_wb_rd == AW'(r)) & (AW'(r) != RZ);

    load_use = bus.i_ex_valid & bus.i_ex_is_load & (bus.i_ex_rd != RZ) &
               ((bus.i_id_uses_rs1 & (bus.i_id_rs1 == bus.i_ex_rd)) |
                (bus.i_id_uses_rs2 & (bus.i_id_rs2 == bus.i_ex_rd)));
    // A last outstanding write retiring this cycle is forwarded from WB.
    raw1 = bus.i_id_uses_rs1 & (bus.i_id_rs1 != RZ) & ~is_zero[bus.i_id_rs1] &
           ~(is_one[bus.i_id_rs1] & dec[bus.i_id_rs1]);
    raw2 = bus.i_id_uses_rs2 & (bus.i_id_rs2 != RZ) & ~is_zero[bus.i_id_rs2] &
           ~(is_one[bus.i_id_rs2] & dec[bus.i_id_rs2]);
    waw  = bus.i_id_writes_rd & (bus.i_id_rd != RZ) & ~is_zero[bus.i_id_rd] & ~bus.i_id_long_lat;
    ovf  = bus.i_id_long_lat & bus.i_id_writes_rd & (bus.i_id_rd != RZ) &
           is_max[bus.i_id_rd] & ~dec[bus.i_id_rd];

    stall = active_q & bus.i_id_valid & ~flush & (load_use | raw1 | raw2 | waw | ovf);
    issue = active_q & bus.i_id_valid & ~stall & ~flush;

    for (int unsigned r = 0; r < NUM_REGS; r++)
      inc[r] = issue & bus.i_id_long_lat & bus.i_id_writes_rd &
               (bus.i_id_rd == AW'(r)) & (AW'(r) != RZ);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      active_q    <= 1'b0;
      flush_cnt_q <= '0;
    end else begin
      active_q    <= active_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  hazard_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .CNT_W    (CNT_W)
  ) u_sb (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_inc     (inc),
    .i_dec     (dec),
    .o_is_zero (is_zero),
    .o_is_one  (is_one),
    .o_is_max  (is_max),
    .o_sb_err  (sb_err)
  );

  assign bus.o_stall   = stall;
  assign bus.o_flush   = flush;
  assign bus.o_pending = ~is_zero;
  assign bus.o_busy    = |(~is_zero);
  assign bus.o_sb_err  = sb_err;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Randomised and directed checks of hazard_scoreboard_unit against a per-register count model.
module tb_hazard_scoreboard_unit;

  localparam int NR   = 32;
  localparam int MAXC = 1;
  localparam int FD   = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_scoreboard_unit_if #(.NUM_REGS(NR)) bus ();

  hazard_scoreboard_unit #(
    .NUM_REGS    (NR),
    .CNT_W       (1),
    .FLUSH_DEPTH (FD)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int m_cnt [NR];
  int m_fl;
  bit m_err;
  bit m_active;
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit retires(input logic [4:0] r);
    return bus.i_wb_valid && bus.i_wb_long_lat && bus.i_wb_rd == r && r != 0;
  endfunction

  function automatic bit src_blocked(input logic [4:0] rs, input logic used);
    if (!used || rs == 0 || m_cnt[rs] == 0) return 1'b0;
    return !(m_cnt[rs] == 1 && retires(rs));
  endfunction

  function automatic void model_eval(output bit st, output bit fo, output bit iss, output bit redir);
    bit need;
    redir = m_active && (bus.i_branch_taken || bus.i_jump_taken);
    fo    = m_active && (redir || m_fl > 0);
    need  = 1'b0;
    if (bus.i_ex_valid && bus.i_ex_is_load && bus.i_ex_rd != 0 &&
        ((bus.i_id_uses_rs1 && bus.i_id_rs1 == bus.i_ex_rd) ||
         (bus.i_id_uses_rs2 && bus.i_id_rs2 == bus.i_ex_rd))) need = 1'b1;
    if (src_blocked(bus.i_id_rs1, bus.i_id_uses_rs1)) need = 1'b1;
    if (src_blocked(bus.i_id_rs2, bus.i_id_uses_rs2)) need = 1'b1;
    if (bus.i_id_writes_rd && bus.i_id_rd != 0 && m_cnt[bus.i_id_rd] > 0 && !bus.i_id_long_lat)
      need = 1'b1;
    if (bus.i_id_long_lat && bus.i_id_writes_rd && bus.i_id_rd != 0 &&
        m_cnt[bus.i_id_rd] == MAXC && !retires(bus.i_id_rd)) need = 1'b1;
    st  = m_active && bus.i_id_valid && !fo && need;
    iss = m_active && bus.i_id_valid && !st && !fo;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NR; r++) m_cnt[r] <= 0;
      m_fl     <= 0;
      m_err    <= 1'b0;
      m_active <= 1'b0;
    end else begin
      bit st, fo, iss, redir, do_inc, do_dec;
      int ri, rw;
      model_eval(st, fo, iss, redir);
      if (redir)         m_fl <= FD - 1;
      else if (m_fl > 0) m_fl <= m_fl - 1;
      ri     = int'(bus.i_id_rd);
      rw     = int'(bus.i_wb_rd);
      do_inc = iss && bus.i_id_long_lat && bus.i_id_writes_rd && ri != 0;
      do_dec = retires(bus.i_wb_rd);
      if (!(do_inc && do_dec && ri == rw)) begin
        if (do_inc) m_cnt[ri] <= m_cnt[ri] + 1;
        if (do_dec) begin
          if (m_cnt[rw] == 0) m_err <= 1'b1;
          else                m_cnt[rw] <= m_cnt[rw] - 1;
        end
      end
      m_active <= 1'b1;
    end
  end

  always @(negedge clk) begin
    bit st, fo, iss, redir;
    logic [NR-1:0] pend;
    model_eval(st, fo, iss, redir);
    pend = '0;
    for (int r = 0; r < NR; r++) pend[r] = (m_cnt[r] != 0);
    chk("m_stall",   bus.o_stall,   st);
    chk("m_flush",   bus.o_flush,   fo);
    chk("m_pending", bus.o_pending, pend);
    chk("m_busy",    bus.o_busy,    |pend);
    chk("m_sb_err",  bus.o_sb_err,  m_err);
  end

  task automatic idle();
    bus.i_id_valid = 0; bus.i_id_rs1 = 0; bus.i_id_rs2 = 0;
    bus.i_id_uses_rs1 = 0; bus.i_id_uses_rs2 = 0; bus.i_id_rd = 0;
    bus.i_id_writes_rd = 0; bus.i_id_long_lat = 0;
    bus.i_ex_valid = 0; bus.i_ex_rd = 0; bus.i_ex_is_load = 0;
    bus.i_wb_valid = 0; bus.i_wb_rd = 0; bus.i_wb_long_lat = 0;
    bus.i_branch_taken = 0; bus.i_jump_taken = 0;
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  task automatic id_long(input logic [4:0] rd);
    bus.i_id_valid = 1; bus.i_id_rd = rd; bus.i_id_writes_rd = 1; bus.i_id_long_lat = 1;
  endtask

  task automatic wb_ret(input logic [4:0] rd);
    bus.i_wb_valid = 1; bus.i_wb_long_lat = 1; bus.i_wb_rd = rd;
  endtask

  initial begin
    idle();
    next(); next();
    sample();
    chk("rst_stall", bus.o_stall, 0);
    chk("rst_flush", bus.o_flush, 0);
    chk("rst_pending", bus.o_pending, 0);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_err", bus.o_sb_err, 0);
    next(); rst_n = 1;
    // First cycle after release: controls stay quiet even with a redirect/hazard present.
    bus.i_branch_taken = 1; bus.i_ex_valid = 1; bus.i_ex_is_load = 1; bus.i_ex_rd = 5;
    bus.i_id_valid = 1; bus.i_id_rs1 = 5; bus.i_id_uses_rs1 = 1;
    sample();
    chk("first_flush", bus.o_flush, 0);
    chk("first_stall", bus.o_stall, 0);

    // Load-use
    next(); idle();
    bus.i_ex_valid = 1; bus.i_ex_is_load = 1; bus.i_ex_rd = 5;
    bus.i_id_valid = 1; bus.i_id_rs1 = 5; bus.i_id_uses_rs1 = 1;
    sample(); chk("lu_stall", bus.o_stall, 1);
    chk("lu_flush_after_first", bus.o_flush, 0);
    next(); bus.i_ex_valid = 0;
    sample(); chk("lu_release", bus.o_stall, 0);
    next(); bus.i_ex_valid = 1; bus.i_ex_rd = 0; bus.i_id_rs1 = 0;
    sample(); chk("lu_x0", bus.o_stall, 0);

    // Scoreboard RAW with WB bypass
    next(); idle(); id_long(7);
    sample(); chk("raw_issue", bus.o_stall, 0);
    next(); idle(); bus.i_id_valid = 1; bus.i_id_rs2 = 7; bus.i_id_uses_rs2 = 1;
    sample(); chk("raw_stall", bus.o_stall, 1);
    chk("raw_pending", bus.o_pending[7], 1);
    chk("raw_busy", bus.o_busy, 1);
    next(); sample(); chk("raw_stall2", bus.o_stall, 1);
    next(); wb_ret(7);
    sample(); chk("raw_bypass", bus.o_stall, 0);
    chk("raw_pend_pre", bus.o_pending[7], 1);
    next(); idle();
    sample(); chk("raw_pend_clr", bus.o_pending, 0);

    // Overflow and WAW with one in-flight write per register
    next(); idle(); id_long(3);
    sample(); chk("ovf_first", bus.o_stall, 0);
    next(); sample(); chk("ovf_stall", bus.o_stall, 1);
    next(); wb_ret(3);
    sample(); chk("ovf_bypass", bus.o_stall, 0);
    next(); idle(); bus.i_id_valid = 1; bus.i_id_rd = 3; bus.i_id_writes_rd = 1;
    sample(); chk("waw_stall", bus.o_stall, 1);
    chk("waw_pending", bus.o_pending[3], 1);
    next(); wb_ret(3);
    sample(); chk("waw_no_bypass", bus.o_stall, 1);
    next(); bus.i_wb_valid = 0; bus.i_wb_long_lat = 0;
    sample(); chk("waw_release", bus.o_stall, 0);
    chk("waw_pend_clr", bus.o_pending[3], 0);

    // Flush window of three cycles, extended by a later jump
    next(); idle();
    bus.i_ex_valid = 1; bus.i_ex_is_load = 1; bus.i_ex_rd = 5;
    bus.i_id_valid = 1; bus.i_id_rs1 = 5; bus.i_id_uses_rs1 = 1;
    bus.i_id_rd = 10; bus.i_id_writes_rd = 1; bus.i_id_long_lat = 1;
    bus.i_branch_taken = 1;
    sample(); chk("fl_c0", bus.o_flush, 1); chk("fl_c0_stall", bus.o_stall, 0);
    next(); bus.i_branch_taken = 0; bus.i_jump_taken = 1;
    sample(); chk("fl_c1", bus.o_flush, 1);
    next(); bus.i_jump_taken = 0;
    sample(); chk("fl_c2", bus.o_flush, 1);
    next(); sample(); chk("fl_c3", bus.o_flush, 1); chk("fl_c3_stall", bus.o_stall, 0);
    next(); sample(); chk("fl_c4", bus.o_flush, 0); chk("fl_c4_stall", bus.o_stall, 1);
    next(); idle();
    sample(); chk("fl_no_issue", bus.o_pending, 0);

    // Simultaneous inc/dec and decrement of an empty counter
    next(); idle(); id_long(9);
    sample(); chk("incdec_first", bus.o_stall, 0);
    next(); wb_ret(9);
    sample(); chk("incdec_nostall", bus.o_stall, 0);
    next(); idle();
    sample(); chk("incdec_hold", bus.o_pending, 32'h0000_0200);
    next(); wb_ret(9);
    next(); idle();
    sample(); chk("incdec_clr", bus.o_pending, 0);
    next(); wb_ret(4);
    sample(); chk("err_pre", bus.o_sb_err, 0);
    next(); idle();
    sample(); chk("err_set", bus.o_sb_err, 1);
    next(); next();
    sample(); chk("err_sticky", bus.o_sb_err, 1);

    // Reset in the middle of a flush window
    next(); idle(); bus.i_branch_taken = 1;
    sample(); chk("rw_flush", bus.o_flush, 1);
    next(); bus.i_branch_taken = 0;
    sample(); chk("rw_window", bus.o_flush, 1);
    rst_n = 0; #1;
    chk("rw_async_flush", bus.o_flush, 0);
    chk("rw_async_err", bus.o_sb_err, 0);
    next(); rst_n = 1;
    sample(); chk("rw_after_flush", bus.o_flush, 0); chk("rw_after_pend", bus.o_pending, 0);
    next();
    sample(); chk("rw_cnt_clear", bus.o_flush, 0);

    // Randomised traffic over a small register window
    for (int c = 0; c < 3000; c++) begin
      next();
      if (!rst_n) rst_n = 1;
      idle();
      if ($urandom_range(0, 999) == 0) begin
        rst_n = 0;
      end else begin
        bus.i_id_valid     = ($urandom_range(0, 3) != 0);
        bus.i_id_rs1       = 5'($urandom_range(0, 7));
        bus.i_id_rs2       = 5'($urandom_range(0, 7));
        bus.i_id_uses_rs1  = $urandom_range(0, 1) != 0;
        bus.i_id_uses_rs2  = $urandom_range(0, 1) != 0;
        bus.i_id_rd        = 5'($urandom_range(0, 7));
        bus.i_id_writes_rd = $urandom_range(0, 3) != 0;
        bus.i_id_long_lat  = $urandom_range(0, 2) == 0;
        bus.i_ex_valid     = $urandom_range(0, 1) != 0;
        bus.i_ex_is_load   = $urandom_range(0, 1) != 0;
        bus.i_ex_rd        = 5'($urandom_range(0, 7));
        bus.i_branch_taken = $urandom_range(0, 19) == 0;
        bus.i_jump_taken   = $urandom_range(0, 29) == 0;
        if ($urandom_range(0, 4) < 2) begin
          int r;
          r = $urandom_range(1, 7);
          if (m_cnt[r] > 0 || $urandom_range(0, 49) == 0) wb_ret(5'(r));
        end
      end
    end

    next(); rst_n = 1; idle();
    next(); next();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
